mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 30 +++
 rtl/mux_scan_next.sv | 28 ++
 rtl/mux_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_scan_pkg : shared types and constants for the mux scanner     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mux_scan_pkg;

    localparam int NCH       = 4;
    localparam int SELW      = 2;
    localparam int CNTW      = 4;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [SELW-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = SELW'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_next.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_scan_next : finds the next set mask bit strictly above ptr    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]  fmask,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] nxt_idx,
    output logic            found
);

    // Scanning downward lets the lowest qualifying index win.
    always_comb begin
        nxt_idx = '0;
        found   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (fmask[i] && (i > int'(ptr))) begin
                nxt_idx = SELW'(i);
                found   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_scan_ctrl : steps a 4:1 mux through masked channels, dwells,  |
// | samples y per channel and publishes one frame.   Rev 1.0          |
// +------------------------------------------------------------------+
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int NCH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NCH-1:0] mask,
    input  logic           abort,
    input  logic           y,
    output logic           s0,
    output logic           s1,
    output logic           busy,
    output logic [NCH-1:0] frame,
    output logic           frame_valid,
    output logic           err
);

    import mux_scan_pkg::*;

    localparam int DW = (DWELL < DWELL_MIN) ? DWELL_MIN :
                        (DWELL > DWELL_MAX) ? DWELL_MAX : DWELL;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DW - 1);

    state_t          r_state,   w_state_nxt;
    logic [SELW-1:0] r_ptr,     w_ptr_nxt;
    logic [CNTW-1:0] r_cnt,     w_cnt_nxt;
    logic [NCH-1:0]  r_fmask,   w_fmask_nxt;
    logic [NCH-1:0]  r_frame_r, w_frame_r_nxt;
    logic [NCH-1:0]  r_frame,   w_frame_nxt;
    logic [SELW-1:0] r_sel,     w_sel_nxt;
    logic            r_busy,    w_busy_nxt;
    logic            r_fv,      w_fv_nxt;
    logic            r_err,     w_err_nxt;

    logic [SELW-1:0] w_next_idx;
    logic            w_next_found;

    mux_scan_next u_next (
        .fmask   (r_fmask),
        .ptr     (r_ptr),
        .nxt_idx (w_next_idx),
        .found   (w_next_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_fmask   <= '0;
            r_frame_r <= '0;
            r_frame   <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_fv      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fmask   <= w_fmask_nxt;
            r_frame_r <= w_frame_r_nxt;
            r_frame   <= w_frame_nxt;
            r_sel     <= w_sel_nxt;
            r_busy    <= w_busy_nxt;
            r_fv      <= w_fv_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_fmask_nxt   = r_fmask;
        w_frame_r_nxt = r_frame_r;
        w_frame_nxt   = r_frame;
        w_fv_nxt      = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (mask != '0) begin
                        w_fmask_nxt   = mask;
                        w_ptr_nxt     = lowest_set(mask);
                        w_cnt_nxt     = CNT_LOAD;
                        w_frame_r_nxt = '0;
                        w_state_nxt   = ST_DWELL;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_DWELL: begin
                if (r_cnt == '0) w_state_nxt = ST_SAMPLE;
                else             w_cnt_nxt   = r_cnt - CNTW'(1);
            end
            ST_SAMPLE: begin
                w_frame_r_nxt[r_ptr] = y;
                if (w_next_found) begin
                    w_ptr_nxt   = w_next_idx;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_DWELL;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_frame_nxt = r_frame_r;
                w_fv_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort overrides everything: no publish, no error, back to idle.
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_frame_nxt = r_frame;
            w_fv_nxt    = 1'b0;
            w_err_nxt   = 1'b0;
        end

        // Selects and busy are registered from the next state so they
        // change on the same edge as the state itself.
        w_sel_nxt  = ((w_state_nxt == ST_DWELL) || (w_state_nxt == ST_SAMPLE))
                     ? w_ptr_nxt : '0;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign s0          = r_sel[1];
    assign s1          = r_sel[0];
    assign busy        = r_busy;
    assign frame       = r_frame;
    assign frame_valid = r_fv;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_scan_ctrl : directed self-checking bench, DWELL=4          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] mask;
    logic       abort;
    logic       y;
    logic       s0, s1, busy, frame_valid, err;
    logic [3:0] frame;
    logic [3:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] seq [0:63];

    mux_scan_ctrl #(.DWELL(4), .NCH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mask        (mask),
        .abort       (abort),
        .y           (y),
        .s0          (s0),
        .s1          (s1),
        .busy        (busy),
        .frame       (frame),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Behavioural 4:1 mux feeding y back to the scanner.
    assign y = data[{s0, s1}];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame and waits for frame_valid; optionally disturbs
    // start/mask mid-frame. c counts edges after the accepting edge.
    task automatic run_frame(input logic [3:0] m, input int exp_cyc,
                             input logic [3:0] exp_frame, input string tag,
                             input bit disturb);
        int c;
        start = 1'b1;
        mask  = m;
        tick();
        start = 1'b0;
        c = 0;
        check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        while (!frame_valid && c < 100) begin
            if (c < 64) seq[c] = {s0, s1};
            if (disturb && c == 7) begin
                start = 1'b1;
                mask  = 4'b0001;
            end
            if (disturb && c == 8) start = 1'b0;
            tick();
            c++;
        end
        check({tag, "_latency"}, c, exp_cyc);
        check({tag, "_frame"}, {28'd0, frame}, {28'd0, exp_frame});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_fv_pulse"}, {31'd0, frame_valid}, 32'd0);
    endtask

    initial begin
        int errs, fvs, busys, bad;

        rst = 1'b1; start = 1'b0; mask = 4'h0; abort = 1'b0; data = 4'h5;
        tick();
        check("reset_outputs", {25'd0, s0, s1, busy, frame, frame_valid, err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Full mask, data 0101
        run_frame(4'hF, 21, 4'h5, "full", 1'b0);
        check("full_seq0",  {30'd0, seq[0]},  32'd0);
        check("full_seq4",  {30'd0, seq[4]},  32'd0);
        check("full_seq5",  {30'd0, seq[5]},  32'd1);
        check("full_seq9",  {30'd0, seq[9]},  32'd1);
        check("full_seq10", {30'd0, seq[10]}, 32'd2);
        check("full_seq15", {30'd0, seq[15]}, 32'd3);
        check("full_seq19", {30'd0, seq[19]}, 32'd3);
        check("full_sel_idle", {30'd0, s0, s1}, 32'd0);

        // Sparse mask 1010: only channels 1 and 3
        run_frame(4'b1010, 11, 4'b0000, "sparse", 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) if (seq[i] == 2'd0 || seq[i] == 2'd2) bad++;
        check("sparse_visits", bad, 0);
        check("sparse_seq0", {30'd0, seq[0]}, 32'd1);
        check("sparse_seq5", {30'd0, seq[5]}, 32'd3);

        // Different data, mask 0110 -> bits 1,2 of 1010
        data = 4'hA;
        run_frame(4'b0110, 11, 4'b0010, "mid", 1'b0);

        // Empty mask
        start = 1'b1; mask = 4'h0;
        tick();
        start = 1'b0;
        errs = 0; fvs = 0; busys = 0;
        for (int i = 0; i < 10; i++) begin
            errs += int'(err); fvs += int'(frame_valid); busys += int'(busy);
            tick();
        end
        check("empty_err_count", errs, 1);
        check("empty_busy", busys, 0);
        check("empty_fv", fvs, 0);

        // Abort during second dwell of a full-mask frame
        start = 1'b1; mask = 4'hF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sel", {30'd0, s0, s1}, 32'd0);
        check("abort_frame", {28'd0, frame}, 32'h2);
        fvs = 0;
        for (int i = 0; i < 30; i++) begin fvs += int'(frame_valid); tick(); end
        check("abort_no_fv", fvs, 0);

        // Start and abort together in idle
        start = 1'b1; abort = 1'b1; mask = 4'hF;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        fvs = 0;
        for (int i = 0; i < 25; i++) begin fvs += int'(frame_valid); tick(); end
        check("start_abort_fv", fvs, 0);

        // Asynchronous reset mid-sample
        start = 1'b1; mask = 4'hF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", {25'd0, s0, s1, busy, frame, frame_valid, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fvs = 0;
        for (int i = 0; i < 3; i++) begin tick(); fvs += int'(frame_valid); end
        check("rst_no_fv", fvs, 0);
        data = 4'h5;
        @(negedge clk);
        start = 1'b1; mask = 4'h1;
        #4;
        run_frame(4'h1, 6, 4'h1, "post_rst", 1'b0);

        // Re-pulsed start and mask change while busy
        data = 4'h9;
        run_frame(4'hF, 21, 4'h9, "disturb", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
